// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store sequencer for the MEM stage, placed directly in front of a
//   doubleword-organised data memory. Takes one request at a time, traps
//   misaligned / out-of-range accesses, extracts and extends load lanes and
//   performs read-modify-write for byte/half/word stores.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (accept on valid && ready)
//   req_op                 0 LDUR,1 LDURSW,2 LDURH,3 LDURB,4 STUR,5 STURW,
//                          6 STURH,7 STURB
//   req_addr, req_wdata    byte address and store data (latched on accept)
//   resp_valid             one-cycle response pulse
//   resp_rdata, resp_err   registered load result / error flag, held
//   MemRead, MemWrite      memory strobes (never both high)
//   mem_addr, mem_wdata    doubleword-aligned address and write word
//   mem_rdata              combinational read data of mem_addr
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]  r_op;
  logic [2:0]  r_lane;
  logic [63:0] r_wdata;
  logic        r_resp_valid;
  logic [63:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [63:0] r_mem_addr;
  logic [63:0] r_mem_wdata;

  // ---------------- request-side checks (combinational, at accept) ----------
  logic        w_accept;
  logic [3:0]  w_req_size;
  logic        w_misaligned;
  logic [64:0] w_req_end;
  logic        w_out_of_range;
  logic        w_req_err;

  assign req_ready      = (r_state == S_IDLE) && !rst;
  assign w_accept       = req_valid && req_ready;
  assign w_req_size     = 4'd8 >> req_op[1:0];
  // size-1 as a 3-bit mask: size 8 wraps to 3'b111, which is exactly right
  assign w_misaligned   = |(req_addr[2:0] & (w_req_size[2:0] - 3'd1));
  // one extra bit so addresses near 2^64 cannot wrap back into range
  assign w_req_end      = {1'b0, req_addr} + {61'd0, w_req_size};
  assign w_out_of_range = w_req_end > 65'(SIZE);
  assign w_req_err      = w_misaligned || w_out_of_range;

  // ---------------- lane extraction / merge for the latched request ---------
  logic [3:0]  w_size;
  logic [5:0]  w_shift;
  logic [63:0] w_rd_shifted;
  logic [63:0] w_wdata_shifted;
  logic [63:0] w_load_data;
  logic [3:0]  w_lane_end;
  logic [7:0]  w_byte_en;
  logic [63:0] w_merged;

  assign w_size          = 4'd8 >> r_op[1:0];
  assign w_shift         = {r_lane, 3'b000};
  assign w_rd_shifted    = mem_rdata >> w_shift;
  assign w_wdata_shifted = r_wdata << w_shift;
  assign w_lane_end      = {1'b0, r_lane} + w_size;

  always_comb begin
    w_load_data = w_rd_shifted;
    case (r_op[1:0])
      2'd1:    w_load_data = {{32{w_rd_shifted[31]}}, w_rd_shifted[31:0]};
      2'd2:    w_load_data = {48'd0, w_rd_shifted[15:0]};
      2'd3:    w_load_data = {56'd0, w_rd_shifted[7:0]};
      default: w_load_data = w_rd_shifted;
    endcase
  end

  // Store bytes replace the captured word only inside [lane, lane+size).
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign w_byte_en[gi] = (4'(gi) >= {1'b0, r_lane}) && (4'(gi) < w_lane_end);
      assign w_merged[gi*8 +: 8] = w_byte_en[gi] ? w_wdata_shifted[gi*8 +: 8]
                                                 : mem_rdata[gi*8 +: 8];
    end
  endgenerate

  // ---------------- FSM ------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)             w_state_next = S_RESP;
          else if (req_op == 3'd4)   w_state_next = S_WRITE;
          else                       w_state_next = S_READ;
        end
      end
      S_READ:  w_state_next = r_op[2] ? S_WRITE : S_RESP;
      S_WRITE: w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // ---------------- registered datapath and outputs --------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= 3'd0;
      r_lane       <= 3'd0;
      r_wdata      <= 64'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 64'd0;
      r_resp_err   <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 64'd0;
      r_mem_wdata  <= 64'd0;
    end else begin
      // Strobes are registered decodes of the state being entered.
      r_resp_valid <= (w_state_next == S_RESP);
      r_mem_read   <= (w_state_next == S_READ);
      r_mem_write  <= (w_state_next == S_WRITE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= req_op;
            r_lane  <= req_addr[2:0];
            r_wdata <= req_wdata;
            if (w_req_err) begin
              r_resp_rdata <= 64'd0;
              r_resp_err   <= 1'b1;
            end else begin
              r_mem_addr <= {req_addr[63:3], 3'b000};
              if (req_op == 3'd4) r_mem_wdata <= req_wdata;
            end
          end
        end
        S_READ: begin
          if (r_op[2]) begin
            r_mem_wdata <= w_merged;
          end else begin
            r_resp_rdata <= w_load_data;
            r_resp_err   <= 1'b0;
          end
        end
        S_WRITE: begin
          r_resp_rdata <= 64'd0;
          r_resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign MemRead    = r_mem_read;
  assign MemWrite   = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Self-checking bench: a doubleword data memory is emulated next to the DUT,
//   and a byte-array reference model predicts results, latency and strobes.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.SIZE(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // data memory emulation (doubleword organised, combinational read)
  logic [63:0] dmem [128];
  assign mem_rdata = MemRead ? dmem[mem_addr[9:3]] : 64'd0;
  always @(posedge clk) if (MemWrite) dmem[mem_addr[9:3]] <= mem_wdata;

  // reference model: plain byte array
  logic [7:0] ref_mem [1024];

  // observations / predictions of the last transaction
  int          obs_lat, exp_lat;
  logic [15:0] obs_rd, obs_wr, exp_rd, exp_wr;
  logic [63:0] obs_rdata, obs_wdata, exp_rdata, exp_wdata;
  logic        obs_err, exp_err;

  task automatic preload();
    for (int i = 0; i < 128; i++) dmem[i] = 64'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
    dmem[8] = 64'd8;   ref_mem[64]  = 8'd8;
    dmem[16] = 64'd16; ref_mem[128] = 8'd16;
  endtask

  function automatic logic [63:0] ref_load(input logic [2:0] op, input logic [63:0] addr);
    int size;
    logic [63:0] v;
    size = 8 >> op[1:0];
    v = 64'd0;
    for (int b = 0; b < size; b++) v = v | (64'(ref_mem[addr + 64'(b)]) << (8 * b));
    if (op == 3'd1 && v[31]) v = v | 64'hFFFF_FFFF_0000_0000;
    return v;
  endfunction

  // Predict, drive one request, and record what the DUT does until it responds.
  task automatic issue(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] wdata);
    int size;
    logic [63:0] base;
    size = 8 >> op[1:0];
    exp_err = ((addr % 64'(size)) != 0) || (addr + 64'(size) > 64'd1024);
    exp_rd = 16'd0; exp_wr = 16'd0; exp_rdata = 64'd0; exp_wdata = 64'd0;
    if (exp_err) exp_lat = 1;
    else if (op < 3'd4) begin
      exp_lat = 2; exp_rd[1] = 1'b1; exp_rdata = ref_load(op, addr);
    end else begin
      for (int b = 0; b < size; b++) ref_mem[addr + 64'(b)] = wdata[8*b +: 8];
      base = addr & ~64'd7;
      for (int b = 0; b < 8; b++) exp_wdata[8*b +: 8] = ref_mem[base + 64'(b)];
      if (op == 3'd4) begin exp_lat = 2; exp_wr[1] = 1'b1; end
      else begin exp_lat = 3; exp_rd[1] = 1'b1; exp_wr[2] = 1'b1; end
    end
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // scramble request fields: the DUT must have latched them
    req_valid = 1'b0; req_op = 3'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    obs_lat = 0; obs_rd = 16'd0; obs_wr = 16'd0;
    obs_rdata = 64'd0; obs_wdata = 64'd0; obs_err = 1'b0;
    for (int c = 1; c <= 8 && obs_lat == 0; c++) begin
      @(negedge clk);
      if (MemRead) obs_rd[c] = 1'b1;
      if (MemWrite) begin obs_wr[c] = 1'b1; obs_wdata = mem_wdata; end
      if (resp_valid) begin obs_lat = c; obs_rdata = resp_rdata; obs_err = resp_err; end
    end
    $display("txn op=%0d addr=%0d wdata=%h lat=%0d rd=%h wr=%h rdata=%h err=%0d",
             op, addr, wdata, obs_lat, obs_rd, obs_wr, obs_rdata, obs_err);
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", req_ready); end
    checks++; if ({resp_valid, resp_err, MemRead, MemWrite} !== 4'b0) begin errors++;
      $display("FAIL rst_flags got=%b want=0000", {resp_valid, resp_err, MemRead, MemWrite}); end
    checks++; if ({resp_rdata, mem_addr, mem_wdata} !== 192'd0) begin errors++;
      $display("FAIL rst_data got=%h/%h/%h want=0", resp_rdata, mem_addr, mem_wdata); end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL rst_release got ready=%b resp=%b want 1 0", req_ready, resp_valid); end
  endtask

  task automatic test_loads();
    logic [63:0] addrs [2] = '{64'd64, 64'd128};
    logic [63:0] wants [2] = '{64'd8, 64'd16};
    for (int i = 0; i < 2; i++) begin
      issue(3'd0, addrs[i], 64'd0);
      checks++; if (obs_lat !== 2) begin errors++; $display("FAIL ld_lat got=%0d want=2", obs_lat); end
      checks++; if (obs_rd !== 16'h0002 || obs_wr !== 16'h0000) begin errors++;
        $display("FAIL ld_strobes got rd=%h wr=%h want 0002 0000", obs_rd, obs_wr); end
      checks++; if (obs_rdata !== wants[i] || obs_err !== 1'b0) begin errors++;
        $display("FAIL ld_data got=%h err=%b want=%h err=0", obs_rdata, obs_err, wants[i]); end
    end
  endtask

  task automatic test_sub_stores();
    logic [2:0]  ops   [7] = '{3'd7, 3'd0, 3'd3, 3'd5, 3'd1, 3'd1, 3'd0};
    logic [63:0] addrs [7] = '{64'd66, 64'd64, 64'd66, 64'd132, 64'd132, 64'd128, 64'd128};
    logic [63:0] wds   [7] = '{64'h1234_5678_9ABC_DEAB, 64'd0, 64'd0, 64'hDEAD_BEEF_8000_0001,
                               64'd0, 64'd0, 64'd0};
    int          lats  [7] = '{3, 2, 2, 3, 2, 2, 2};
    logic [15:0] wrs   [7] = '{16'h4, 16'h0, 16'h0, 16'h4, 16'h0, 16'h0, 16'h0};
    logic [63:0] rds   [7] = '{64'd0, 64'h00AB_0008, 64'hAB, 64'd0, 64'hFFFF_FFFF_8000_0001,
                               64'd16, 64'h8000_0001_0000_0010};
    logic [63:0] wws   [7] = '{64'h00AB_0008, 64'd0, 64'd0, 64'h8000_0001_0000_0010,
                               64'd0, 64'd0, 64'd0};
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], addrs[i], wds[i]);
      checks++; if (obs_lat !== lats[i]) begin errors++;
        $display("FAIL st_lat[%0d] got=%0d want=%0d", i, obs_lat, lats[i]); end
      checks++; if (obs_rd !== 16'h0002 || obs_wr !== wrs[i]) begin errors++;
        $display("FAIL st_strobes[%0d] got rd=%h wr=%h want 0002 %h", i, obs_rd, obs_wr, wrs[i]); end
      checks++; if (obs_rdata !== rds[i] || obs_err !== 1'b0) begin errors++;
        $display("FAIL st_rdata[%0d] got=%h err=%b want=%h", i, obs_rdata, obs_err, rds[i]); end
      if (wrs[i] != 16'h0) begin
        checks++; if (obs_wdata !== wws[i]) begin errors++;
          $display("FAIL st_wdata[%0d] got=%h want=%h", i, obs_wdata, wws[i]); end
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0]  ops   [3] = '{3'd0, 3'd6, 3'd0};
    logic [63:0] addrs [3] = '{64'd68, 64'd1023, 64'd1024};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], addrs[i], 64'hFFFF);
      checks++; if (obs_lat !== 1 || obs_err !== 1'b1) begin errors++;
        $display("FAIL err_resp[%0d] got lat=%0d err=%b want 1 1", i, obs_lat, obs_err); end
      checks++; if (obs_rdata !== 64'd0 || obs_rd !== 16'd0 || obs_wr !== 16'd0) begin errors++;
        $display("FAIL err_quiet[%0d] got rdata=%h rd=%h wr=%h want 0", i, obs_rdata, obs_rd, obs_wr); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [3] = '{64'd64, 64'd128, 64'd0};
    logic [63:0] wants [3] = '{64'd8, 64'd16, 64'd0};
    int idx = 0, low = 0;
    int acc [3] = '{0, 0, 0};
    logic [63:0] got [$];
    preload();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (resp_valid) got.push_back(resp_rdata);
      if (!req_ready) low++;
      req_valid = (idx < 3);
      if (idx < 3) begin req_op = 3'd0; req_addr = addrs[idx]; end
      if (req_valid && req_ready) begin acc[idx] = c; idx++; end
    end
    req_valid = 1'b0;
    $display("txn b2b accepts=%0d at %0d,%0d,%0d responses=%0d busy=%0d", idx, acc[0], acc[1], acc[2], got.size(), low);
    checks++; if (idx !== 3) begin errors++; $display("FAIL b2b_accepts got=%0d want=3", idx); end
    checks++; if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin errors++;
      $display("FAIL b2b_spacing got=%0d,%0d want=3,3", acc[1] - acc[0], acc[2] - acc[1]); end
    checks++; if (low !== 6) begin errors++; $display("FAIL b2b_busy got=%0d want=6", low); end
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL b2b_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== wants[i]) begin errors++;
        $display("FAIL b2b_data[%0d] got=%h want=%h", i, got[i], wants[i]); end
    end
  endtask

  task automatic test_reset_mid_op();
    int wr_seen = 0, rv_seen = 0;
    preload();
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd7; req_addr = 64'd64; req_wdata = 64'hAB;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL rmo_read got=%b want=1", MemRead); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmo_ready got=%b want=1", req_ready); end
      end
      if (MemWrite) wr_seen++;
      if (resp_valid) rv_seen++;
    end
    $display("txn reset-mid-op writes=%0d responses=%0d", wr_seen, rv_seen);
    checks++; if (wr_seen !== 0 || rv_seen !== 0) begin errors++;
      $display("FAIL rmo_quiet got wr=%0d resp=%0d want 0 0", wr_seen, rv_seen); end
    issue(3'd0, 64'd64, 64'd0);
    checks++; if (obs_lat !== 2 || obs_rdata !== 64'd8) begin errors++;
      $display("FAIL rmo_load got lat=%0d rdata=%h want 2 8", obs_lat, obs_rdata); end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [63:0] addr;
    int size, bad = 0;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom);
      size = 8 >> op[1:0];
      if ($urandom_range(0, 4) != 0) addr = 64'($urandom_range(0, 1023)) & ~64'(size - 1);
      else addr = 64'($urandom_range(0, 1100));
      issue(op, addr, {$urandom, $urandom});
      checks++; if (obs_lat !== exp_lat || obs_err !== exp_err) begin errors++;
        $display("FAIL rnd_resp[%0d] got lat=%0d err=%b want %0d %b", n, obs_lat, obs_err, exp_lat, exp_err); end
      checks++; if (obs_rd !== exp_rd || obs_wr !== exp_wr || (obs_rd & obs_wr) !== 16'd0) begin errors++;
        $display("FAIL rnd_strobes[%0d] got rd=%h wr=%h want %h %h", n, obs_rd, obs_wr, exp_rd, exp_wr); end
      checks++; if (obs_rdata !== exp_rdata) begin errors++;
        $display("FAIL rnd_rdata[%0d] got=%h want=%h", n, obs_rdata, exp_rdata); end
      if (exp_wr != 16'd0) begin
        checks++; if (obs_wdata !== exp_wdata) begin errors++;
          $display("FAIL rnd_wdata[%0d] got=%h want=%h", n, obs_wdata, exp_wdata); end
      end
    end
    for (int w = 0; w < 128; w++)
      for (int b = 0; b < 8; b++)
        if (dmem[w][8*b +: 8] !== ref_mem[w*8 + b]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rnd_memory got=%0d bad bytes want=0", bad); end
  endtask

  initial begin
    preload();
    test_reset();
    test_loads();
    test_sub_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer for the MEM stage of the LEGv8 datapath, sitting directly upstream of `data_mem`. It accepts one memory request at a time from the pipeline and drives `data_mem`'s `MemRead`/`MemWrite`/`addr`/`data` controls. It performs byte/half/word lane extraction and sign or zero extension for loads, and read-modify-write for sub-doubleword stores. Misaligned or out-of-range accesses are trapped before they reach memory.

## Interface

Parameters:
- `SIZE`, 1024: data memory size in bytes. Byte addresses `>= SIZE` are out of range.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; a request is accepted on an edge where `req_valid && req_ready`.
- `req_op`  in  3  operation code:
  - 0 LDUR (64b)
  - 1 LDURSW (32b, sign-extended)
  - 2 LDURH (16b, zero-extended)
  - 3 LDURB (8b, zero-extended)
  - 4 STUR (64b)
  - 5 STURW (32b)
  - 6 STURH (16b)
  - 7 STURB (8b)
- `req_addr`  in  `WORD`  byte address.
- `req_wdata`  in  `WORD`  store data; the low bytes are used for sub-word stores.
- `resp_valid`  out  1  single-cycle response pulse; no backpressure.
- `resp_rdata`  out  `WORD`  load result; 0 for stores and on error.
- `resp_err`  out  1  misaligned or out-of-range access; valid with `resp_valid`.
- `MemRead`  out  1  to `data_mem`.
- `MemWrite`  out  1  to `data_mem`.
- `mem_addr`  out  `WORD`  to `data_mem` `addr`; always doubleword-aligned (`{req_addr[63:3],3'b0}`).
- `mem_wdata`  out  `WORD`  word driven onto `data_mem` `data` by the top level when `MemWrite`.
- `mem_rdata`  in  `WORD`  `data_mem` `data` when `MemRead`; combinational read of `mem_addr`.

## Operation

- Little-endian. The byte lane is `addr[2:0]`. Access size is 8/4/2/1 bytes by op.
- Error check at accept:
  - Misaligned if `addr % size != 0`.
  - Out of range if `addr + size > SIZE`.
  - On error, no memory access; go straight to RESP with `resp_err=1`.
- Request fields (op, addr, wdata) are latched on accept. Later changes to `req_*` are ignored.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: `req_ready=1`. On accept:
    - error → RESP
    - STUR → WRITE
    - any other op → READ
  - READ: `MemRead=1`, `mem_addr` = aligned address. `mem_rdata` is captured at the closing edge.
    - Load → RESP, with extracted and extended data registered into `resp_rdata`.
    - Sub-word store → WRITE, with merged word registered (captured word, store bytes replaced in their lanes).
  - WRITE: `MemWrite=1`, `mem_wdata` = merged word (STUR: latched wdata). Memory commits at the closing edge. → RESP.
  - RESP: `resp_valid=1` for exactly one cycle. → IDLE.
- `MemRead` and `MemWrite` are never high in the same cycle. Neither is high outside READ/WRITE.
- Outputs `resp_rdata` and `resp_err` are registered and held until the next response. Qualify them with `resp_valid`.

## Timing

- Accept on edge E0. The cycle after E0 is cycle 1.
- Loads: READ in cycle 1, `resp_valid` in cycle 2.
- STUR: WRITE in cycle 1, `resp_valid` in cycle 2.
- Sub-word stores: READ in cycle 1, WRITE in cycle 2, `resp_valid` in cycle 3.
- Errors: `resp_valid` in cycle 1.
- `req_ready` is low from cycle 1 through the RESP cycle. `req_ready` returns high in the cycle after RESP, so the minimum issue interval is 3/3/4/2 cycles for the cases above.
- Reset behaviour:
  - While `rst` is high, on every edge: state ← IDLE; `resp_valid`, `resp_err`, `resp_rdata`, `MemRead`, `MemWrite`, `mem_addr`, `mem_wdata` ← 0.
  - `req_ready` = 0 while `rst` is high.
  - Reset mid-operation (READ or WRITE) aborts the request. No `MemWrite` pulse follows, and no response is issued.
- `req_valid` held high in RESP is not accepted until IDLE. No request is lost or duplicated.

## Test plan

Memory preload: word 8 at byte 64, word 16 at byte 128, all other words 0.

1. LDUR addr 64 → `MemRead` high exactly in cycle 1; `resp_valid` in cycle 2 with `resp_rdata=8`, `resp_err=0`. LDUR addr 128 → 16.
2. STURB addr 66, wdata `0x...AB` → `MemRead` in cycle 1, `MemWrite` in cycle 2 with `mem_wdata=0x0000_0000_00AB_0008`, response in cycle 3. A following LDUR 64 → `0xAB0008`; LDURB 66 → `0xAB`.
3. STURW addr 132, wdata `0x8000_0001` → LDURSW 132 returns `0xFFFF_FFFF_8000_0001`; LDURSW 128 returns 16; LDUR 128 returns `0x8000_0001_0000_0010`.
4. Errors:
   - LDUR addr 68 → `resp_valid` in cycle 1, `resp_err=1`, `resp_rdata=0`, no `MemRead`/`MemWrite` pulse.
   - STURH addr 1023 → `resp_err=1`.
   - LDUR addr 1024 → `resp_err=1`.
5. `req_valid` held high with 3 back-to-back LDUR (64, 128, 0) → `req_ready` low while busy. Exactly 3 responses (8, 16, 0), accepts spaced 3 cycles apart.
6. Assert `rst` for one cycle during READ of STURB addr 64 → no `MemWrite` pulse, no `resp_valid`. LDUR 64 afterwards still returns 8, and `req_ready` returns 1 the cycle after reset deasserts.
